// File: rtl/serial_mem_burst_ctrl_pkg.sv
// Shared types and width helpers for the serial burst memory controller.
// Header and data words are both assumed to span at least two serial chunks.
package serial_mem_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_FDATA,
    ST_FILL,
    ST_RDATA
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int hdr_chunks_f(input int addr_bits, input int bank_bits,
                                      input int serial_bits);
    return (2 + 2 * addr_bits + bank_bits + serial_bits - 1) / serial_bits;
  endfunction

endpackage

// File: rtl/serial_mem_burst_ctrl_mem_bank_array.sv
// NUM_BANKS x 2^ADDR_BITS x DATA_BITS flop memory, one write port and one
// combinational read port; out-of-range banks ignore writes and read as zero.
module mem_bank_array #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int NUM_BANKS = 2,
  parameter int BANK_BITS = 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [BANK_BITS-1:0] wr_bank,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [BANK_BITS-1:0] rd_bank,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam logic [BANK_BITS:0] NB = (BANK_BITS + 1)'(NUM_BANKS);

  logic [DATA_BITS-1:0] mem [NUM_BANKS][2**ADDR_BITS];
  logic wr_ok, rd_ok;

  assign wr_ok = ({1'b0, wr_bank} < NB);
  assign rd_ok = ({1'b0, rd_bank} < NB);

  // NOTE: the array has no reset; contents survive rst_n, and leaving reset
  // off keeps it a plain register file rather than thousands of reset flops.
  always_ff @(posedge clk) begin
    if (we && wr_ok) mem[wr_bank][wr_addr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (rd_ok) rdata = mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/serial_mem_burst_ctrl.sv
// Serial command front end driving a banked flop memory with single-word,
// burst write, burst read and fill operations; addresses wrap within a bank.
module serial_mem_burst_ctrl
  import serial_mem_burst_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = 4,
  parameter int DATA_BITS   = 8,
  parameter int SERIAL_BITS = 2,
  parameter int NUM_BANKS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [SERIAL_BITS-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [SERIAL_BITS-1:0] out_data,
  output logic                   busy
);

  localparam int BANK_BITS   = clog2_min1(NUM_BANKS);
  localparam int HDR_CHUNKS  = hdr_chunks_f(ADDR_BITS, BANK_BITS, SERIAL_BITS);
  localparam int HW          = HDR_CHUNKS * SERIAL_BITS;
  localparam int DATA_CHUNKS = DATA_BITS / SERIAL_BITS;
  localparam int HCW         = clog2_min1(HDR_CHUNKS);
  localparam int CCW         = clog2_min1(DATA_CHUNKS);
  localparam logic [HCW-1:0] HDR_LAST   = HCW'(HDR_CHUNKS - 1);
  localparam logic [CCW-1:0] CHUNK_LAST = CCW'(DATA_CHUNKS - 1);

  state_e                  state_q, state_d;
  logic [HW-SERIAL_BITS-1:0] hdr_q, hdr_d;
  logic [HCW-1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [CCW-1:0]          chunk_q, chunk_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d, cnt_q, cnt_d;
  logic [BANK_BITS-1:0]    bank_q, bank_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d, out_sr_q, out_sr_d;
  logic                    out_valid_q, out_valid_d;

  logic                    accept;
  logic [HW-1:0]           hdr_full;
  op_e                     hdr_op;
  logic [ADDR_BITS-1:0]    hdr_addr, hdr_len;
  logic [BANK_BITS-1:0]    hdr_bank;
  logic [DATA_BITS-1:0]    word_full;
  logic                    mem_we;
  logic [DATA_BITS-1:0]    mem_wdata, rd_data;
  logic [ADDR_BITS-1:0]    rd_addr;
  logic [BANK_BITS-1:0]    rd_bank;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_WDATA) || (state_q == ST_FDATA);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? out_sr_q[SERIAL_BITS-1:0] : '0;

  // The header is decoded from the stored chunks plus the one arriving now,
  // so the next state is known at the edge that accepts the final chunk.
  assign hdr_full  = {in_data, hdr_q};
  assign hdr_op    = op_e'(hdr_full[1:0]);
  assign hdr_addr  = hdr_full[2 +: ADDR_BITS];
  assign hdr_len   = hdr_full[2 + ADDR_BITS +: ADDR_BITS];
  assign hdr_bank  = hdr_full[2 + 2 * ADDR_BITS +: BANK_BITS];
  assign word_full = {in_data, wdata_q[DATA_BITS-1:SERIAL_BITS]};

  assign rd_addr = (state_q == ST_IDLE) ? hdr_addr : addr_q;
  assign rd_bank = (state_q == ST_IDLE) ? hdr_bank : bank_q;

  // NOTE: every value written here gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_cnt_d   = hdr_cnt_q;
    chunk_d     = chunk_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    wdata_d     = wdata_q;
    out_sr_d    = out_sr_q;
    out_valid_d = out_valid_q;
    mem_we      = 1'b0;
    mem_wdata   = wdata_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (hdr_cnt_q == HDR_LAST) begin
          hdr_cnt_d = '0;
          hdr_d     = '0;
          chunk_d   = '0;
          addr_d    = hdr_addr;
          cnt_d     = hdr_len;
          bank_d    = hdr_bank;
          case (hdr_op)
            OP_WRITE: state_d = ST_WDATA;
            OP_FILL:  state_d = ST_FDATA;
            OP_READ: begin
              state_d     = ST_RDATA;
              out_sr_d    = rd_data;
              out_valid_d = 1'b1;
              addr_d      = hdr_addr + ADDR_BITS'(1);
            end
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          hdr_d     = hdr_full[HW-1:SERIAL_BITS];
          hdr_cnt_d = hdr_cnt_q + HCW'(1);
        end
      end
      ST_WDATA, ST_FDATA: if (accept) begin
        wdata_d = word_full;
        if (chunk_q == CHUNK_LAST) begin
          chunk_d = '0;
          if (state_q == ST_FDATA) begin
            state_d = ST_FILL;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = word_full;
            addr_d    = addr_q + ADDR_BITS'(1);
            cnt_d     = cnt_q - ADDR_BITS'(1);
            if (cnt_q == '0) state_d = ST_IDLE;
          end
        end else begin
          chunk_d = chunk_q + CCW'(1);
        end
      end
      ST_FILL: begin
        mem_we = 1'b1;
        addr_d = addr_q + ADDR_BITS'(1);
        cnt_d  = cnt_q - ADDR_BITS'(1);
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      ST_RDATA: begin
        if (chunk_q == CHUNK_LAST) begin
          chunk_d = '0;
          if (cnt_q == '0) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_sr_d    = '0;
          end else begin
            out_sr_d = rd_data;
            addr_d   = addr_q + ADDR_BITS'(1);
            cnt_d    = cnt_q - ADDR_BITS'(1);
          end
        end else begin
          out_sr_d = out_sr_q >> SERIAL_BITS;
          chunk_d  = chunk_q + CCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      hdr_cnt_q   <= '0;
      chunk_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      bank_q      <= '0;
      wdata_q     <= '0;
      out_sr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      chunk_q     <= chunk_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      wdata_q     <= wdata_d;
      out_sr_q    <= out_sr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // A reset landing on the last data chunk must not commit the word.
  mem_bank_array #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS),
    .NUM_BANKS(NUM_BANKS),
    .BANK_BITS(BANK_BITS)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we && rst_n),
    .wr_bank (bank_q),
    .wr_addr (addr_q),
    .wdata   (mem_wdata),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_serial_mem_burst_ctrl.sv
// Bench for serial_mem_burst_ctrl: a word-level memory model predicts the
// read chunk stream, checked every cycle, plus hand-computed literal checks.
module tb_serial_mem_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] model_mem [2][16];
  logic [1:0] exp_q [$];
  logic [1:0] cap_q [$];
  logic [7:0] wbuf  [$];

  serial_mem_burst_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: the output must follow the expected chunk stream exactly.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      check("out_valid_hi", {31'b0, out_valid}, 1);
      check("out_data", {30'b0, out_data}, {30'b0, e});
    end else begin
      check("out_valid_lo", {31'b0, out_valid}, 0);
      check("out_data_zero", {30'b0, out_data}, 0);
    end
  end

  always @(negedge clk) if (out_valid) cap_q.push_back(out_data);

  function automatic logic [7:0] cap_word(input int i);
    return {cap_q[4*i+3], cap_q[4*i+2], cap_q[4*i+1], cap_q[4*i]};
  endfunction

  task automatic send_chunk(input logic [1:0] c, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_header(input logic [1:0] op, input int addr, input int len,
                             input int bank, input bit gaps);
    int h;
    h = int'(op) | (addr << 2) | (len << 6) | (bank << 10);
    for (int k = 0; k < 6; k++) send_chunk(2'((h >> (2 * k)) & 3), gaps);
    if (op == 2'b10) begin
      for (int i = 0; i <= len; i++) begin
        logic [7:0] w;
        w = (bank < 2) ? model_mem[bank][(addr + i) % 16] : 8'h00;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'((w >> (2 * k)) & 8'h03));
      end
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_chunk(w[2*k +: 2], gaps);
  endtask

  // Waits for IDLE, driving junk chunks whenever the DUT is not accepting.
  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      if (!busy) break;
      in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
      in_data  = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (i >= 400) check("idle_timeout", 0, 1);
  endtask

  task automatic do_write(input int bank, input int addr, input int len, input bit gaps);
    send_header(2'b01, addr, len, bank, gaps);
    for (int i = 0; i <= len; i++) send_word(wbuf[i], gaps);
    for (int i = 0; i <= len; i++) if (bank < 2) model_mem[bank][(addr + i) % 16] = wbuf[i];
    wait_idle();
  endtask

  task automatic do_read(input int bank, input int addr, input int len);
    cap_q.delete();
    send_header(2'b10, addr, len, bank, 1'b0);
    wait_idle();
  endtask

  task automatic do_fill(input int bank, input int addr, input int len,
                         input logic [7:0] w, input bit gaps);
    send_header(2'b11, addr, len, bank, gaps);
    send_word(w, gaps);
    wait_idle();
    for (int i = 0; i <= len; i++) if (bank < 2) model_mem[bank][(addr + i) % 16] = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a5_lit [4];
    logic [7:0] burst_lit [4];
    int n;
    a5_lit    = '{2'd1, 2'd1, 2'd2, 2'd2};
    burst_lit = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {30'b0, out_data}, 0);
    rst_n = 1'b1;

    // Known contents in both banks so later "unchanged" checks are meaningful.
    wbuf.delete();
    for (int i = 0; i < 16; i++) wbuf.push_back(8'(i * 17 + 3));
    do_write(0, 0, 15, 1'b0);
    wbuf.delete();
    for (int i = 0; i < 16; i++) wbuf.push_back(8'(i * 29 + 100));
    do_write(1, 0, 15, 1'b0);

    // Single word 0xA5 at bank0 addr3.
    wbuf.delete(); wbuf.push_back(8'hA5);
    do_write(0, 3, 0, 1'b0);
    do_read(0, 3, 0);
    check("a5_nchunks", cap_q.size(), 4);
    if (cap_q.size() == 4)
      for (int k = 0; k < 4; k++) check("a5_chunk", {30'b0, cap_q[k]}, {30'b0, a5_lit[k]});

    // Burst wrapping from addr14 to addr1.
    wbuf.delete();
    for (int i = 0; i < 4; i++) wbuf.push_back(burst_lit[i]);
    do_write(0, 14, 3, 1'b0);
    do_read(0, 14, 3);
    check("burst_nchunks", cap_q.size(), 16);
    if (cap_q.size() == 16)
      for (int i = 0; i < 4; i++) check("burst_word", {24'b0, cap_word(i)}, {24'b0, burst_lit[i]});

    // Fill bank1 with 0x3C; count FILL cycles while junk chunks are offered.
    send_header(2'b11, 0, 15, 1, 1'b0);
    send_word(8'h3C, 1'b0);
    n = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      in_data = 2'($urandom_range(0, 3));
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("fill_busy_cycles", n, 16);
    for (int i = 0; i < 16; i++) model_mem[1][i] = 8'h3C;
    @(posedge clk); #1;
    do_read(1, 0, 15);
    check("fill_nchunks", cap_q.size(), 64);
    if (cap_q.size() == 64)
      for (int i = 0; i < 16; i++) check("fill_word", {24'b0, cap_word(i)}, 32'h3C);
    do_read(0, 0, 15);

    // Reset in the middle of a WRITE data word.
    wbuf.delete(); wbuf.push_back(8'h5A);
    do_write(0, 7, 0, 1'b0);
    send_header(2'b01, 7, 0, 0, 1'b0);
    send_chunk(2'd1, 1'b0);
    send_chunk(2'd3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", {31'b0, in_ready}, 1);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    rst_n = 1'b1;
    do_read(0, 7, 0);
    check("midrst_nchunks", cap_q.size(), 4);
    if (cap_q.size() == 4) check("midrst_word", {24'b0, cap_word(0)}, 32'h5A);

    // Gapped header/data must land the same as gap-free traffic.
    wbuf.delete();
    for (int i = 0; i < 5; i++) wbuf.push_back(8'(8'hC1 + i * 13));
    do_write(1, 10, 4, 1'b1);
    do_fill(0, 8, 2, 8'h99, 1'b1);
    do_read(1, 0, 15);
    do_read(0, 0, 15);

    // NOP header then a READ header back to back.
    cap_q.delete();
    send_header(2'b00, 5, 2, 1, 1'b0);
    check("nop_busy", {31'b0, busy}, 0);
    send_header(2'b10, 14, 1, 0, 1'b0);
    wait_idle();
    check("nop_read_nchunks", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      check("nop_read_w0", {24'b0, cap_word(0)}, 32'h11);
      check("nop_read_w1", {24'b0, cap_word(1)}, 32'h22);
    end

    repeat (5) @(posedge clk);
    check("exp_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
